// File: rtl/mem_stage.sv
// mem_stage: memory-access stage of the five-stage RV32 pipeline.
// Drives the data-memory request/ready handshake, lane-steers store data,
// formats load data and produces the MEM/WB pipeline register.
// Optional feature: define MEM_MISALIGN_TRAP_EN to trap misaligned
// halfword/word accesses as bus errors instead of issuing them.
module mem_stage #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] aluResult,
  input  logic [31:0] aluOperand2,
  input  logic [4:0]  rd,
  input  logic [2:0]  funct3,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic        memToReg,
  input  logic        regWrite,
  output logic        dmemReq,
  output logic        dmemWe,
  output logic [31:0] dmemAddr,
  output logic [31:0] dmemWdata,
  output logic [3:0]  dmemBe,
  input  logic [31:0] dmemRdata,
  input  logic        dmemReady,
  output logic        stall,
  output logic [31:0] readDataOut,
  output logic [31:0] aluResultOut,
  output logic [4:0]  rdOut,
  output logic        memToRegOut,
  output logic        regWriteOut,
  output logic        busErrOut
);

  // Counter must be able to hold TIMEOUT_CYCLES itself.
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TIMEOUT_VAL = CW'(TIMEOUT_CYCLES);

  typedef enum logic {
    ST_IDLE,
    ST_WAIT
  } state_t;

  state_t          state;
  logic [CW-1:0]   wait_cnt;

  logic [1:0]  lane;
  logic        is_byte;
  logic        is_half;
  logic        access;
  logic        misaligned;
  logic        complete;
  logic        timeout;
  logic        abort;
  logic        is_load;
  logic [31:0] shifted;
  logic [31:0] load_data;

  assign lane    = aluResult[1:0];
  assign access  = memRead | memWrite;
  assign is_load = memRead & ~memWrite;

  // Width decode; anything that is not a byte or halfword code is a word.
  always_comb begin
    is_byte = (funct3 == 3'b000) || (funct3 == 3'b100);
    is_half = (funct3 == 3'b001) || (funct3 == 3'b101);
  end

`ifdef MEM_MISALIGN_TRAP_EN
  assign misaligned = is_half ? lane[0] : (!is_byte && (lane != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  // Handshake and stall. The request stays up through WAIT because upstream
  // holds the instruction stable while stalled.
  assign dmemReq  = resetn & ((state == ST_WAIT) | (access & ~misaligned));
  assign complete = dmemReq & dmemReady;
  assign timeout  = (state == ST_WAIT) & ~dmemReady & (wait_cnt == TIMEOUT_VAL);
  assign abort    = timeout | (access & misaligned);
  assign stall    = resetn & access & ~complete & ~abort;

  assign dmemWe   = memWrite;
  assign dmemAddr = {aluResult[31:2], 2'b00};

  // Store lane steering: replicate data across lanes, enable only the target bytes.
  always_comb begin
    dmemWdata = aluOperand2;
    dmemBe    = 4'b1111;
    if (is_byte) begin
      dmemWdata = {4{aluOperand2[7:0]}};
      dmemBe    = 4'b0001 << lane;
    end else if (is_half) begin
      dmemWdata = {2{aluOperand2[15:0]}};
      dmemBe    = 4'b0011 << {lane[1], 1'b0};
    end
    if (!memWrite) begin
      dmemBe = 4'b0000;
    end
  end

  // Load formatting: halfwords select by lane[1] only, bytes by the full lane.
  always_comb begin
    if (is_half) begin
      shifted = dmemRdata >> {lane[1], 4'b0000};
    end else begin
      shifted = dmemRdata >> {lane, 3'b000};
    end
    case (funct3)
      3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
      3'b100:  load_data = {24'h000000, shifted[7:0]};
      3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
      3'b101:  load_data = {16'h0000, shifted[15:0]};
      default: load_data = dmemRdata;
    endcase
  end

  // Access FSM, wait counter and MEM/WB register (bubble on stall, error on abort).
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state        <= ST_IDLE;
      wait_cnt     <= '0;
      readDataOut  <= '0;
      aluResultOut <= '0;
      rdOut        <= '0;
      memToRegOut  <= 1'b0;
      regWriteOut  <= 1'b0;
      busErrOut    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (dmemReq && !dmemReady) begin
            state    <= ST_WAIT;
            wait_cnt <= CW'(1);
          end
        end
        ST_WAIT: begin
          if (complete || timeout) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        default: begin
          state    <= ST_IDLE;
          wait_cnt <= '0;
        end
      endcase

      aluResultOut <= aluResult;
      rdOut        <= rd;
      if (abort) begin
        readDataOut <= '0;
        memToRegOut <= 1'b0;
        regWriteOut <= 1'b0;
        busErrOut   <= 1'b1;
      end else if (stall) begin
        readDataOut <= '0;
        memToRegOut <= 1'b0;
        regWriteOut <= 1'b0;
        busErrOut   <= 1'b0;
      end else begin
        readDataOut <= is_load ? load_data : 32'h0;
        memToRegOut <= memToReg;
        regWriteOut <= regWrite;
        busErrOut   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: self-checking bench for mem_stage.
// Directed cases for the documented scenarios plus a randomized stream of
// back-to-back loads/stores with random wait states, checked against an
// arithmetic reference model. Also honours MEM_MISALIGN_TRAP_EN if defined.
module tb_mem_stage;

  localparam int TIMEOUT = 16;

  logic        clk;
  logic        resetn;
  logic [31:0] aluResult;
  logic [31:0] aluOperand2;
  logic [4:0]  rd;
  logic [2:0]  funct3;
  logic        memRead;
  logic        memWrite;
  logic        memToReg;
  logic        regWrite;
  logic        dmemReq;
  logic        dmemWe;
  logic [31:0] dmemAddr;
  logic [31:0] dmemWdata;
  logic [3:0]  dmemBe;
  logic [31:0] dmemRdata;
  logic        dmemReady;
  logic        stall;
  logic [31:0] readDataOut;
  logic [31:0] aluResultOut;
  logic [4:0]  rdOut;
  logic        memToRegOut;
  logic        regWriteOut;
  logic        busErrOut;

  int n_compared = 0;
  int n_mismatch = 0;

  mem_stage #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk(clk), .resetn(resetn),
    .aluResult(aluResult), .aluOperand2(aluOperand2), .rd(rd), .funct3(funct3),
    .memRead(memRead), .memWrite(memWrite), .memToReg(memToReg), .regWrite(regWrite),
    .dmemReq(dmemReq), .dmemWe(dmemWe), .dmemAddr(dmemAddr), .dmemWdata(dmemWdata),
    .dmemBe(dmemBe), .dmemRdata(dmemRdata), .dmemReady(dmemReady), .stall(stall),
    .readDataOut(readDataOut), .aluResultOut(aluResultOut), .rdOut(rdOut),
    .memToRegOut(memToRegOut), .regWriteOut(regWriteOut), .busErrOut(busErrOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: load result from the memory word, using plain arithmetic.
  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] a,
                                             input logic [31:0] word);
    logic [31:0] b;
    logic [31:0] h;
    b = (word / (32'd1 << (8 * a))) % 32'd256;
    h = (word / (32'd1 << (16 * (a / 2)))) % 32'd65536;
    case (f3)
      3'd0:    return (b >= 32'd128) ? b + 32'hFFFFFF00 : b;
      3'd4:    return b;
      3'd1:    return (h >= 32'd32768) ? h + 32'hFFFF0000 : h;
      3'd5:    return h;
      default: return word;
    endcase
  endfunction

  function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [1:0] a);
    case (f3)
      3'd0, 3'd4: return 4'(1 << a);
      3'd1, 3'd5: return 4'(3 << (2 * (a / 2)));
      default:    return 4'd15;
    endcase
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] op);
    case (f3)
      3'd0, 3'd4: return (op % 32'd256) * 32'h01010101;
      3'd1, 3'd5: return (op % 32'd65536) * 32'h00010001;
      default:    return op;
    endcase
  endfunction

  task automatic drive(input logic [31:0] addr, input logic [31:0] op2, input logic [4:0] dst,
                       input logic [2:0] f3, input logic rd_en, input logic wr_en,
                       input logic m2r, input logic rw);
    aluResult   = addr;
    aluOperand2 = op2;
    rd          = dst;
    funct3      = f3;
    memRead     = rd_en;
    memWrite    = wr_en;
    memToReg    = m2r;
    regWrite    = rw;
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    dmemReady = 1'b0;
    dmemRdata = 32'h0;
    drive(32'h0000_0104, 32'hCAFE_F00D, 5'd7, 3'd2, 1'b1, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    @(negedge clk);
    n_compared++;
    if ({readDataOut, aluResultOut, rdOut, memToRegOut, regWriteOut, busErrOut} !== 72'h0) begin
      n_mismatch++;
      $display("[TB] FAIL reset_regs: got %h want 0",
               {readDataOut, aluResultOut, rdOut, memToRegOut, regWriteOut, busErrOut});
    end
    n_compared++;
    if ({dmemReq, stall} !== 2'b00) begin
      n_mismatch++;
      $display("[TB] FAIL reset_req_stall: got %b want 00", {dmemReq, stall});
    end
    n_compared++;
    if (dmemAddr !== 32'h0000_0104) begin
      n_mismatch++;
      $display("[TB] FAIL reset_addr_follow: got %h want 00000104", dmemAddr);
    end
    drive(32'h0, 32'h0, 5'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_lw_zero_wait;
    drive(32'h0000_0100, 32'h0, 5'd3, 3'd2, 1'b1, 1'b0, 1'b1, 1'b1);
    dmemRdata = 32'hDEAD_BEEF;
    dmemReady = 1'b1;
    #1;
    n_compared++;
    if ({dmemReq, stall, dmemWe, dmemBe, dmemAddr} !== {1'b1, 1'b0, 1'b0, 4'h0, 32'h100}) begin
      n_mismatch++;
      $display("[TB] FAIL lw_bus: got req=%b stall=%b we=%b be=%h addr=%h want 1 0 0 0 00000100",
               dmemReq, stall, dmemWe, dmemBe, dmemAddr);
    end
    @(negedge clk);
    dmemReady = 1'b0;
    n_compared++;
    if ({readDataOut, rdOut, memToRegOut, regWriteOut, busErrOut} !== {32'hDEAD_BEEF, 5'd3, 3'b110}) begin
      n_mismatch++;
      $display("[TB] FAIL lw_wb: got data=%h rd=%0d m2r=%b rw=%b err=%b want deadbeef 3 1 1 0",
               readDataOut, rdOut, memToRegOut, regWriteOut, busErrOut);
    end
  endtask

  task automatic test_lb_sign;
    logic [31:0] want [2];
    logic [2:0]  f3s [2];
    want[0] = 32'hFFFF_FF80; f3s[0] = 3'd0;
    want[1] = 32'h0000_0080; f3s[1] = 3'd4;
    for (int i = 0; i < 2; i++) begin
      drive(32'h0000_0103, 32'h0, 5'd9, f3s[i], 1'b1, 1'b0, 1'b1, 1'b1);
      dmemRdata = 32'h80FF_FFFF;
      dmemReady = 1'b1;
      @(negedge clk);
      dmemReady = 1'b0;
      n_compared++;
      if (readDataOut !== want[i]) begin
        n_mismatch++;
        $display("[TB] FAIL lb_format f3=%0d: got %h want %h", f3s[i], readDataOut, want[i]);
      end
    end
  endtask

  task automatic test_sh_wait;
    drive(32'h0000_0102, 32'h1234_ABCD, 5'd4, 3'd1, 1'b0, 1'b1, 1'b0, 1'b0);
    dmemReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_compared++;
      if ({stall, dmemReq, dmemWe, dmemBe, dmemWdata} !== {3'b111, 4'b1100, 32'hABCD_ABCD}) begin
        n_mismatch++;
        $display("[TB] FAIL sh_wait cyc%0d: got stall=%b req=%b we=%b be=%b wd=%h want 1 1 1 1100 abcdabcd",
                 i, stall, dmemReq, dmemWe, dmemBe, dmemWdata);
      end
      @(negedge clk);
      n_compared++;
      if ({regWriteOut, memToRegOut, busErrOut} !== 3'b000) begin
        n_mismatch++;
        $display("[TB] FAIL sh_bubble cyc%0d: got %b want 000", i, {regWriteOut, memToRegOut, busErrOut});
      end
      dmemReady = (i == 2);
    end
    #1;
    n_compared++;
    if (stall !== 1'b0) begin
      n_mismatch++;
      $display("[TB] FAIL sh_done_stall: got %b want 0", stall);
    end
    @(negedge clk);
    dmemReady = 1'b0;
    n_compared++;
    if ({aluResultOut, rdOut, busErrOut} !== {32'h102, 5'd4, 1'b0}) begin
      n_mismatch++;
      $display("[TB] FAIL sh_wb: got addr=%h rd=%0d err=%b want 00000102 4 0", aluResultOut, rdOut, busErrOut);
    end
  endtask

  task automatic test_timeout;
    drive(32'h0000_0200, 32'h0, 5'd6, 3'd2, 1'b1, 1'b0, 1'b1, 1'b1);
    dmemReady = 1'b0;
    for (int i = 0; i < TIMEOUT; i++) begin
      #1;
      n_compared++;
      if ({stall, dmemReq} !== 2'b11) begin
        n_mismatch++;
        $display("[TB] FAIL timeout_stall cyc%0d: got %b want 11", i, {stall, dmemReq});
      end
      @(negedge clk);
      n_compared++;
      if ({regWriteOut, busErrOut} !== 2'b00) begin
        n_mismatch++;
        $display("[TB] FAIL timeout_bubble cyc%0d: got %b want 00", i, {regWriteOut, busErrOut});
      end
    end
    #1;
    n_compared++;
    if (stall !== 1'b0) begin
      n_mismatch++;
      $display("[TB] FAIL timeout_release: got stall=%b want 0", stall);
    end
    @(negedge clk);
    n_compared++;
    if ({busErrOut, regWriteOut, memToRegOut, readDataOut} !== {3'b100, 32'h0}) begin
      n_mismatch++;
      $display("[TB] FAIL timeout_err: got err=%b rw=%b m2r=%b data=%h want 1 0 0 0",
               busErrOut, regWriteOut, memToRegOut, readDataOut);
    end
    drive(32'h0000_0040, 32'h0, 5'd1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    #1;
    n_compared++;
    if ({dmemReq, stall} !== 2'b00) begin
      n_mismatch++;
      $display("[TB] FAIL timeout_idle: got req/stall=%b want 00", {dmemReq, stall});
    end
    @(negedge clk);
    n_compared++;
    if ({busErrOut, regWriteOut} !== 2'b01) begin
      n_mismatch++;
      $display("[TB] FAIL timeout_err_pulse: got err=%b rw=%b want 0 1", busErrOut, regWriteOut);
    end
  endtask

  task automatic test_reset_in_wait;
    drive(32'h0000_0300, 32'h0, 5'd12, 3'd2, 1'b1, 1'b0, 1'b1, 1'b1);
    dmemReady = 1'b0;
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b0;
    #1;
    n_compared++;
    if ({dmemReq, stall} !== 2'b00) begin
      n_mismatch++;
      $display("[TB] FAIL rstwait_comb: got req/stall=%b want 00", {dmemReq, stall});
    end
    @(negedge clk);
    n_compared++;
    if ({readDataOut, aluResultOut, rdOut, memToRegOut, regWriteOut, busErrOut, stall} !== 73'h0) begin
      n_mismatch++;
      $display("[TB] FAIL rstwait_regs: got %h want 0",
               {readDataOut, aluResultOut, rdOut, memToRegOut, regWriteOut, busErrOut, stall});
    end
    resetn = 1'b1;
    drive(32'h0, 32'h0, 5'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    dmemRdata = 32'h5555_AAAA;
    dmemReady = 1'b1;
    #1;
    n_compared++;
    if ({dmemReq, stall} !== 2'b00) begin
      n_mismatch++;
      $display("[TB] FAIL rstwait_late_req: got %b want 00", {dmemReq, stall});
    end
    @(negedge clk);
    dmemReady = 1'b0;
    n_compared++;
    if ({regWriteOut, memToRegOut, busErrOut, readDataOut} !== 35'h0) begin
      n_mismatch++;
      $display("[TB] FAIL rstwait_late_wb: got rw=%b m2r=%b err=%b data=%h want 0 0 0 0",
               regWriteOut, memToRegOut, busErrOut, readDataOut);
    end
  endtask

  task automatic test_misaligned;
    drive(32'h0000_0101, 32'h0, 5'd8, 3'd2, 1'b1, 1'b0, 1'b1, 1'b1);
    dmemRdata = 32'h1122_3344;
    dmemReady = 1'b1;
    #1;
`ifdef MEM_MISALIGN_TRAP_EN
    n_compared++;
    if ({dmemReq, stall} !== 2'b00) begin
      n_mismatch++;
      $display("[TB] FAIL misalign_req: got %b want 00", {dmemReq, stall});
    end
    @(negedge clk);
    n_compared++;
    if ({busErrOut, regWriteOut} !== 2'b10) begin
      n_mismatch++;
      $display("[TB] FAIL misalign_err: got err=%b rw=%b want 1 0", busErrOut, regWriteOut);
    end
`else
    n_compared++;
    if ({dmemReq, stall, dmemAddr} !== {2'b10, 32'h100}) begin
      n_mismatch++;
      $display("[TB] FAIL misalign_bus: got req=%b stall=%b addr=%h want 1 0 00000100",
               dmemReq, stall, dmemAddr);
    end
    @(negedge clk);
    n_compared++;
    if ({readDataOut, regWriteOut, busErrOut} !== {32'h1122_3344, 2'b10}) begin
      n_mismatch++;
      $display("[TB] FAIL misalign_load: got data=%h rw=%b err=%b want 11223344 1 0",
               readDataOut, regWriteOut, busErrOut);
    end
`endif
    dmemReady = 1'b0;
  endtask

  task automatic test_random_back_to_back;
    logic [31:0] addr, op2, word, want_data;
    logic [4:0]  dst;
    logic [2:0]  f3;
    logic        rd_en, wr_en, m2r, rw, is_load, active;
    int          lat, kind;
    for (int n = 0; n < 80; n++) begin
      addr = $urandom;
`ifdef MEM_MISALIGN_TRAP_EN
      addr[1:0] = 2'b00;
`endif
      op2  = $urandom;
      word = $urandom;
      dst  = 5'($urandom_range(0, 31));
      f3   = 3'($urandom_range(0, 7));
      m2r  = 1'($urandom_range(0, 1));
      rw   = 1'($urandom_range(0, 1));
      kind = $urandom_range(0, 3);
      rd_en = (kind == 0) || (kind == 2);
      wr_en = (kind == 1) || (kind == 2);
      active  = rd_en || wr_en;
      is_load = rd_en && !wr_en;
      lat = active ? $urandom_range(0, 4) : 0;
      want_data = is_load ? model_load(f3, addr[1:0], word) : 32'h0;

      drive(addr, op2, dst, f3, rd_en, wr_en, m2r, rw);
      dmemReady = (lat == 0);
      dmemRdata = (lat == 0) ? word : $urandom;
      #1;
      n_compared++;
      if ({dmemReq, dmemWe, dmemAddr, dmemBe} !==
          {active, wr_en, addr[31:2], 2'b00, wr_en ? model_be(f3, addr[1:0]) : 4'h0}) begin
        n_mismatch++;
        $display("[TB] FAIL rnd_bus #%0d: got req=%b we=%b addr=%h be=%b want req=%b be=%b",
                 n, dmemReq, dmemWe, dmemAddr, dmemBe, active,
                 wr_en ? model_be(f3, addr[1:0]) : 4'h0);
      end
      if (wr_en) begin
        n_compared++;
        if (dmemWdata !== model_wdata(f3, op2)) begin
          n_mismatch++;
          $display("[TB] FAIL rnd_wdata #%0d: got %h want %h", n, dmemWdata, model_wdata(f3, op2));
        end
      end
      for (int i = 0; i < lat; i++) begin
        if (i > 0) #1;
        n_compared++;
        if (stall !== 1'b1) begin
          n_mismatch++;
          $display("[TB] FAIL rnd_stall #%0d cyc%0d: got %b want 1", n, i, stall);
        end
        @(negedge clk);
        n_compared++;
        if ({regWriteOut, memToRegOut, busErrOut} !== 3'b000) begin
          n_mismatch++;
          $display("[TB] FAIL rnd_bubble #%0d cyc%0d: got %b want 000", n, i,
                   {regWriteOut, memToRegOut, busErrOut});
        end
        dmemReady = (i == lat - 1);
        dmemRdata = (i == lat - 1) ? word : $urandom;
      end
      if (lat > 0) #1;
      n_compared++;
      if (stall !== 1'b0) begin
        n_mismatch++;
        $display("[TB] FAIL rnd_release #%0d: got stall=%b want 0", n, stall);
      end
      @(negedge clk);
      dmemReady = 1'b0;
      n_compared++;
      if ({readDataOut, aluResultOut, rdOut, memToRegOut, regWriteOut, busErrOut} !==
          {want_data, addr, dst, m2r, rw, 1'b0}) begin
        n_mismatch++;
        $display("[TB] FAIL rnd_wb #%0d f3=%0d: got data=%h alu=%h rd=%0d m2r=%b rw=%b err=%b want data=%h alu=%h rd=%0d m2r=%b rw=%b err=0",
                 n, f3, readDataOut, aluResultOut, rdOut, memToRegOut, regWriteOut, busErrOut,
                 want_data, addr, dst, m2r, rw);
      end
    end
  endtask

  initial begin
    $display("[TB] mem_stage bench start");
    test_reset();
    test_lw_zero_wait();
    test_lb_sign();
    test_sh_wait();
    test_timeout();
    test_reset_in_wait();
    test_misaligned();
    test_random_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
    $finish;
  end

endmodule
